// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the WISC unified-memory arbiter.
// Block size and bus widths are configured here; everything else derives from them.
package mem_arb_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 16;

  localparam int unsigned WORD_IDX_BITS = $clog2(WORDS_PER_BLOCK);
  // Byte offset within a block: words are two bytes wide.
  localparam int unsigned BLK_OFF_BITS  = $clog2(2 * WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite
  } state_e;

  typedef enum logic {
    SideI,
    SideD
  } side_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/fill handshake plus memory port of the arbiter.
// slave is the arbiter view; master is the caches-plus-memory environment.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                     i_req;
  logic [ADDR_W-1:0]        i_addr;
  logic                     i_busy;
  logic                     i_done;

  logic                     d_req;
  logic                     d_we;
  logic [ADDR_W-1:0]        d_addr;
  logic [DATA_W-1:0]        d_wdata;
  logic                     d_busy;
  logic                     d_done;

  logic                     fill_valid;
  logic [WORD_IDX_BITS-1:0] fill_word;
  logic [DATA_W-1:0]        fill_data;

  logic                     mem_en;
  logic                     mem_wr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_busy, i_done, d_busy, d_done, fill_valid, fill_word, fill_data,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_busy, i_done, d_busy, d_done, fill_valid, fill_word, fill_data,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the pipelined unified memory between I-cache fills and D-cache fills/stores.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: D wins).
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus_io
);
  import mem_arb_pkg::*;

  localparam int unsigned CntW = WORD_IDX_BITS + 1;
  localparam logic [CntW-1:0] IssueMax = CntW'(WORDS_PER_BLOCK);
  localparam logic [WORD_IDX_BITS-1:0] RetLast = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BlkMask = ~ADDR_W'((2 * WORDS_PER_BLOCK) - 1);

  state_e                   state_q, state_d;
  side_e                    side_q, side_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [CntW-1:0]          issue_cnt_q, issue_cnt_d;
  logic [WORD_IDX_BITS-1:0] ret_cnt_q, ret_cnt_d;
  logic                     i_busy_q, i_busy_d;
  logic                     d_busy_q, d_busy_d;
  logic                     wr_done_q, wr_done_d;
  logic                     mem_en_q, mem_en_d;
  logic                     mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;

  logic  grant;
  side_e win;
  logic  fill_ret;
  logic  fill_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  side_e last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle && grant) begin
      last_grant_d = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SideI;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    grant = bus_io.i_req || bus_io.d_req;
    win   = SideI;
    if (bus_io.d_req && bus_io.i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = (last_grant_q == SideI) ? SideD : SideI;
`else
      win = SideD;
`endif
    end else if (bus_io.d_req) begin
      win = SideD;
    end
  end

  // Returns are counted, not timed: the memory's fixed latency is not modelled here.
  always_comb begin
    fill_ret  = (state_q == StFill) && bus_io.mem_rvalid;
    fill_last = fill_ret && (ret_cnt_q == RetLast);
  end

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    i_busy_d    = i_busy_q;
    d_busy_d    = d_busy_q;
    wr_done_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          side_d = win;
          if (win == SideD && bus_io.d_we) begin
            state_d     = StWrite;
            d_busy_d    = 1'b1;
            wr_done_d   = 1'b1;
            mem_en_d    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = bus_io.d_addr;
            mem_wdata_d = bus_io.d_wdata;
          end else begin
            state_d     = StFill;
            base_d      = ((win == SideD) ? bus_io.d_addr : bus_io.i_addr) & BlkMask;
            i_busy_d    = (win == SideI);
            d_busy_d    = (win == SideD);
            // First beat goes out with the grant so issue runs gap-free from FILL cycle 0.
            mem_en_d    = 1'b1;
            mem_addr_d  = base_d;
            issue_cnt_d = CntW'(1);
            ret_cnt_d   = '0;
          end
        end
      end

      StFill: begin
        if (issue_cnt_q < IssueMax) begin
          mem_en_d    = 1'b1;
          mem_addr_d  = base_q + (ADDR_W'(issue_cnt_q) << 1);
          issue_cnt_d = issue_cnt_q + CntW'(1);
        end
        if (fill_ret) begin
          ret_cnt_d = ret_cnt_q + WORD_IDX_BITS'(1);
        end
        if (fill_last) begin
          state_d     = StIdle;
          i_busy_d    = 1'b0;
          d_busy_d    = 1'b0;
          ret_cnt_d   = '0;
          issue_cnt_d = '0;
        end
      end

      StWrite: begin
        state_d  = StIdle;
        d_busy_d = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      side_q      <= SideI;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      i_busy_q    <= 1'b0;
      d_busy_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      i_busy_q    <= i_busy_d;
      d_busy_q    <= d_busy_d;
      wr_done_q   <= wr_done_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Fill completion must coincide with the last returned word, so that part of done is
  // decoded from the return; the store completion is the registered WRITE-cycle flag.
  assign bus_io.i_done     = fill_last && (side_q == SideI);
  assign bus_io.d_done     = wr_done_q || (fill_last && (side_q == SideD));
  assign bus_io.i_busy     = i_busy_q;
  assign bus_io.d_busy     = d_busy_q;
  assign bus_io.fill_valid = fill_ret;
  assign bus_io.fill_word  = ret_cnt_q;
  assign bus_io.fill_data  = fill_ret ? bus_io.mem_rdata : '0;
  assign bus_io.mem_en     = mem_en_q;
  assign bus_io.mem_wr     = mem_wr_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: latency-4 pipelined memory model, expected issue
// addresses, returned words and stores queued at stimulus time and popped at the outputs.
module tb_mem_arbiter;

  localparam int Lat = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic        first;
  } exp_addr_t;

  typedef struct packed {
    logic        d_side;
    logic [2:0]  word;
    logic [15:0] data;
    logic        last;
  } exp_ret_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_wr_t;

  logic clk;
  logic rst;
  logic spur;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   ret_seen;
  int   n_i_done;
  int   n_wr;
  int   last_issue;
  bit   tb_last;

  exp_addr_t exp_addr[$];
  exp_ret_t  exp_ret[$];
  exp_wr_t   exp_wr[$];
  exp_addr_t ea;
  exp_ret_t  er;
  exp_wr_t   ew;

  logic [Lat-1:0] pv;
  logic [15:0]    pa[Lat];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory model: fixed latency, cleared by the shared reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[Lat-2:0], bus.mem_en && !bus.mem_wr};
      pa[0] <= bus.mem_addr;
      for (int i = 1; i < Lat; i++) pa[i] <= pa[i-1];
    end
  end

  assign bus.mem_rvalid = pv[Lat-1] | spur;
  assign bus.mem_rdata  = mdata(pa[Lat-1]);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_fill(input bit d_side, input logic [15:0] addr);
    logic [15:0] base;
    exp_addr_t a;
    exp_ret_t  r;
    base = addr & 16'hFFF0;
    for (int w = 0; w < 8; w++) begin
      a.addr   = base + 16'(2 * w);
      a.first  = (w == 0);
      exp_addr.push_back(a);
      r.d_side = d_side;
      r.word   = 3'(w);
      r.data   = mdata(a.addr);
      r.last   = (w == 7);
      exp_ret.push_back(r);
    end
    tb_last = d_side;
  endtask

  // Holds requests until their done, then drops them; optionally checks the IDLE bubble.
  task automatic serve(input int budget, input bit chk_bubble);
    int done_cyc;
    bit have_done;
    bit prev_busy;
    int n;
    have_done = 1'b0;
    done_cyc  = 0;
    prev_busy = bus.i_busy | bus.d_busy;
    n         = 0;
    while ((bus.i_req || bus.d_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (chk_bubble && have_done && !prev_busy && (bus.i_busy || bus.d_busy))
        check_eq("bubble", 32'(cyc - done_cyc), 32'd2);
      prev_busy = bus.i_busy | bus.d_busy;
      if (bus.i_done) begin
        bus.i_req = 1'b0;
        have_done = 1'b1;
        done_cyc  = cyc;
      end
      if (bus.d_done) begin
        bus.d_req = 1'b0;
        have_done = 1'b1;
        done_cyc  = cyc;
      end
    end
    if (bus.i_req || bus.d_req) check_eq("serve_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("sb_empty", 32'(exp_ret.size() + exp_addr.size() + exp_wr.size()), 32'd0);
  endtask

  task automatic pair(input logic [15:0] da, input logic [15:0] ia);
    bit win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win_d = (tb_last == 1'b0);
`else
    win_d = 1'b1;
`endif
    if (win_d) begin
      push_fill(1'b1, da);
      push_fill(1'b0, ia);
    end else begin
      push_fill(1'b0, ia);
      push_fill(1'b1, da);
    end
    bus.d_addr = da;
    bus.d_we   = 1'b0;
    bus.i_addr = ia;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    serve(600, 1'b1);
  endtask

  // Output monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en && !bus.mem_wr) begin
        if (exp_addr.size() == 0) begin
          check_eq("addr_underflow", 32'd1, 32'd0);
        end else begin
          ea = exp_addr.pop_front();
          check_eq("mem_addr", 32'(bus.mem_addr), 32'(ea.addr));
          if (!ea.first) check_eq("issue_gap", 32'(cyc - last_issue), 32'd1);
          last_issue = cyc;
        end
      end
      if (bus.fill_valid) begin
        ret_seen++;
        if (exp_ret.size() == 0) begin
          check_eq("ret_underflow", 32'd1, 32'd0);
        end else begin
          er = exp_ret.pop_front();
          check_eq("fill_word", 32'(bus.fill_word), 32'(er.word));
          check_eq("fill_data", 32'(bus.fill_data), 32'(er.data));
          check_eq("ret_busy", {30'd0, bus.i_busy, bus.d_busy}, er.d_side ? 32'd1 : 32'd2);
          check_eq("ret_done", {30'd0, bus.i_done, bus.d_done},
                   er.last ? (er.d_side ? 32'd1 : 32'd2) : 32'd0);
        end
      end else if (bus.mem_en && bus.mem_wr) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          check_eq("wr_underflow", 32'd1, 32'd0);
        end else begin
          ew = exp_wr.pop_front();
          check_eq("wr_addr", 32'(bus.mem_addr), 32'(ew.addr));
          check_eq("wr_data", 32'(bus.mem_wdata), 32'(ew.data));
          check_eq("wr_done", {30'd0, bus.i_done, bus.d_done}, 32'd1);
        end
      end else if (bus.i_done || bus.d_done) begin
        check_eq("stray_done", {30'd0, bus.i_done, bus.d_done}, 32'd0);
      end
      if (bus.i_done) n_i_done++;
    end
  end

  initial begin
    int snap;
    int n;
    exp_wr_t w;
    cyc = 0; n_checks = 0; n_fail = 0; ret_seen = 0; n_i_done = 0; n_wr = 0;
    last_issue = 0; tb_last = 1'b0;
    rst = 1'b1; spur = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_busy", {30'd0, bus.i_busy, bus.d_busy}, 32'd0);
    check_eq("rst_done", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    check_eq("rst_fill_valid", 32'(bus.fill_valid), 32'd0);

    // Spurious return while idle.
    @(negedge clk);
    spur = 1'b1;
    #1;
    check_eq("spur_fill_valid", 32'(bus.fill_valid), 32'd0);
    @(negedge clk);
    spur = 1'b0;

    // Plain I fill from a mid-block address.
    push_fill(1'b0, 16'h1236);
    bus.i_addr = 16'h1236;
    bus.i_req  = 1'b1;
    serve(200, 1'b0);

    // I request withdrawn mid-fill: service still completes with done.
    snap = n_i_done;
    push_fill(1'b0, 16'h2004);
    bus.i_addr = 16'h2004;
    bus.i_req  = 1'b1;
    n = ret_seen;
    for (int k = 0; k < 100 && ret_seen < n + 3; k++) @(negedge clk);
    bus.i_req = 1'b0;
    for (int k = 0; k < 100 && exp_ret.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("middrop_done", 32'(n_i_done - snap), 32'd1);
    check_eq("middrop_empty", 32'(exp_ret.size()), 32'd0);

    // Simultaneous fill requests, twice.
    pair(16'h5008, 16'h6030);
    pair(16'h7000, 16'h801E);

    // Single-word store.
    snap = n_wr;
    w.addr = 16'h0042;
    w.data = 16'hBEEF;
    exp_wr.push_back(w);
    tb_last = 1'b1;
    bus.d_addr  = 16'h0042;
    bus.d_wdata = 16'hBEEF;
    bus.d_we    = 1'b1;
    bus.d_req   = 1'b1;
    serve(50, 1'b0);
    bus.d_we = 1'b0;
    check_eq("wr_count", 32'(n_wr - snap), 32'd1);

    // Reset in the middle of a fill.
    push_fill(1'b0, 16'h3000);
    bus.i_addr = 16'h3000;
    bus.i_req  = 1'b1;
    n = ret_seen;
    for (int k = 0; k < 100 && ret_seen < n + 3; k++) @(negedge clk);
    check_eq("pre_rst_returns", 32'(ret_seen - n), 32'd3);
    snap = n_i_done;
    #2;
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    check_eq("arst_mem_en", 32'(bus.mem_en), 32'd0);
    check_eq("arst_busy", {30'd0, bus.i_busy, bus.d_busy}, 32'd0);
    check_eq("arst_done", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    check_eq("arst_fill_valid", 32'(bus.fill_valid), 32'd0);
    exp_addr.delete();
    exp_ret.delete();
    tb_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("arst_no_done", 32'(n_i_done - snap), 32'd0);

    // Fresh fill after reset must restart at word 0.
    push_fill(1'b0, 16'h4010);
    bus.i_addr = 16'h4010;
    bus.i_req  = 1'b1;
    serve(200, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
